gam_connection_mem_seq: RTL and testbench
=========================================

Name: gam_connection_mem_seq

Overview:
- Clocked, parametrised successor of the GAM per-class edge store.
- Holds a symmetric node-to-node connection matrix per class: a presence bit plus a saturating age per edge.
- Connect commands arrive through a valid/ready handshake. A learning-done edge triggers a multi-cycle prune sweep that removes aged edges and flags isolated nodes.
- Sits between the GAM winner-search stage (issues connect commands) and the node-validity/classification stage (reads `node_isolated`).

Parameters:
- CLASS_COUNT, 4, number of class slots; index 0 is reserved/unused.
- NODE_COUNT, 16, node slots per class; index 0 is the null node.
- AGE_W, 4, edge age width in bits.
- AGE_MAX, 8, prune threshold; an edge is pruned when age >= AGE_MAX (must be < 2^AGE_W).
- CLS_W, $clog2(CLASS_COUNT), derived.
- NODE_W, $clog2(NODE_COUNT), derived.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  connect request
- cmd_ready  out  1  high only in IDLE with learning_done low
- cmd_class  in  CLS_W  class of request
- cmd_node1  in  NODE_W  first node of request
- cmd_node2  in  NODE_W  second node of request
- cmd_err  out  1  one-cycle pulse when an accepted command is invalid
- learning_done  in  1  level input; its rising edge requests a prune
- busy  out  1  high when state != IDLE
- prune_done  out  1  one-cycle pulse at prune completion
- node_isolated  out  CLASS_COUNT*NODE_COUNT  bit [c*NODE_COUNT+i] set by prune when node i of class c has no edges
- q_class  in  CLS_W  combinational query address
- q_node1  in  NODE_W  combinational query address
- q_node2  in  NODE_W  combinational query address
- q_present  out  1  presence bit at the query address
- q_age  out  AGE_W  age at the query address
- edge_count  out  16  live undirected edges (optional feature)

Behaviour:
- Reset (async, rst_n=0):
  - all presence bits and ages 0; node_isolated all 0; state IDLE.
  - cmd_err, prune_done, busy all 0; learning_done edge register 0.
- States: IDLE, CONNECT, PRUNE, DONE.
- IDLE:
  - A learning_done rise (or a pending prune flag) goes to PRUNE, with priority over commands.
  - Otherwise cmd_valid && cmd_ready accepts the command: operands are registered and the FSM goes to CONNECT.
- CONNECT (1 cycle), for class c, nodes a=node1, b=node2:
  - Command is invalid if c==0, c>=CLASS_COUNT, a==0, b==0, a==b, or a/b >= NODE_COUNT.
    - Invalid: no matrix change; cmd_err pulses on this cycle's edge.
  - Valid:
    - Set presence[c][a][b] and presence[c][b][a] to 1; set both ages to 0, including when the edge already exists.
    - For every j in 1..NODE_COUNT-1 with j!=a, j!=b and presence[c][a][j]==1: increment age[c][a][j] and age[c][j][a] together, saturating at 2^AGE_W-1.
    - All qualifying j update in parallel (row read-modify-write).
  - Return to IDLE. Throughput is 1 command per 2 cycles.
- learning_done rise detection:
  - Rise = learning_done & ~registered value.
  - A rise seen outside IDLE sets a pending flag; prune starts on the next IDLE cycle.
  - learning_done held high through reset release counts as a rise on the first clock.
- PRUNE:
  - Row counter (c,i) sweeps c=1..CLASS_COUNT-1, i=1..NODE_COUNT-1, one row per cycle.
  - Per row: clear presence and zero age for every j with age[c][i][j] >= AGE_MAX.
  - node_isolated[c][i] <= ~|(surviving presence row).
  - Symmetric ages keep per-row decisions consistent.
  - Duration is (CLASS_COUNT-1)*(NODE_COUNT-1) cycles; then DONE.
- DONE: prune_done pulses for 1 cycle; clear the pending flag; go to IDLE.
- Commands are blocked (cmd_ready=0) while learning_done is high; connections resume when it falls.
- Index-0 rows/columns are never written and read as 0.
- Reset asserted mid-CONNECT or mid-PRUNE aborts the operation and applies full reset values.

Optional Feature:
- GAM_CONN_EDGE_COUNT_EN:
  - Defined: edge_count tracks live undirected edges.
    - +1 on a valid CONNECT creating a new edge; +0 if the edge already existed.
    - −1 per pruned edge, counted only when i<j.
    - Reset value 0.
  - Undefined: edge_count tied to 0 and its counter logic is absent.

Decomposition:
- GAM_package gets:
  - CLASS_COUNT/NODE_COUNT/AGE_MAX defaults;
  - edge_t struct {connection_presence, age[AGE_W]};
  - gam_conn_state_e enum (IDLE, CONNECT, PRUNE, DONE);
  - the NULL_NODE=0 constant.
- One sub-module: gam_conn_row_update. It is combinational and, given one row plus a mode (age/prune), produces the next row and the row-OR. It is used by both CONNECT and PRUNE.

Test Plan:
Configuration: CLASS_COUNT=3, NODE_COUNT=8, AGE_W=4, AGE_MAX=3.
- Connect (c1,2,3) -> q_present=1 and q_age=0 at both [1][2][3] and [1][3][2]; cmd_ready low exactly 1 cycle; edge_count=1.
- Connect (1,2,3), then (1,2,4) ×3, then learning_done 0->1 -> ages of 2-3 reach 3; after prune, 2-3 is absent, node_isolated[1][3]=1, [1][2]=0, [1][4]=0; prune_done pulses 14 cycles after PRUNE entry.
- Commands (0,2,3), (1,0,3), (1,5,5) -> cmd_err pulse each; matrix unchanged; edge_count unchanged.
- Connect (1,2,3), then (1,2,4) ×20 -> q_age[1][2][3]=15 (saturated, no wrap).
- learning_done rise while in CONNECT -> PRUNE starts on the next IDLE cycle; cmd_ready stays 0 until learning_done falls.
- rst_n low in PRUNE row 5 -> all outputs return to reset values immediately; busy=0; node_isolated=0.

Source files
------------

// File: rtl/gam_connection_mem_seq_pkg.sv
// Shared types and defaults for the GAM per-class connection store.
package gam_connection_mem_seq_pkg;

    localparam int CLASS_COUNT_DEF = 4;
    localparam int NODE_COUNT_DEF  = 16;
    localparam int AGE_W_DEF       = 4;
    localparam int AGE_MAX_DEF     = 8;
    localparam int NULL_NODE       = 0;

    typedef struct packed {
        logic                 connection_presence;
        logic [AGE_W_DEF-1:0] age;
    } edge_t;

    typedef enum logic [1:0] {
        IDLE,
        CONNECT,
        PRUNE,
        DONE
    } gam_conn_state_e;

endpackage

// File: rtl/gam_connection_mem_seq_row_update.sv
// Combinational next-row generator for one adjacency row: ages neighbours and
// links node_b (age mode), or drops aged-out edges (prune mode).
module gam_conn_row_update #(
    parameter int NODE_COUNT = 16,
    parameter int NODE_W     = $clog2(NODE_COUNT),
    parameter int AGE_W      = 4,
    parameter int AGE_MAX    = 8
) (
    input  logic                              prune_mode,
    input  logic [NODE_W-1:0]                 node_a,
    input  logic [NODE_W-1:0]                 node_b,
    input  logic [NODE_COUNT-1:0]             pres_row,
    input  logic [NODE_COUNT-1:0][AGE_W-1:0]  age_row,
    output logic [NODE_COUNT-1:0]             next_pres,
    output logic [NODE_COUNT-1:0][AGE_W-1:0]  next_age,
    output logic                              row_or
);

    localparam logic [AGE_W-1:0] AGE_SAT = '1;
    localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(AGE_MAX);

    function automatic logic [AGE_W-1:0] sat_inc(input logic [AGE_W-1:0] a);
        return (a == AGE_SAT) ? a : a + 1'b1;
    endfunction

    always_comb begin
        next_pres = pres_row;
        next_age  = age_row;
        for (int j = 1; j < NODE_COUNT; j++) begin
            if (prune_mode) begin
                if (age_row[NODE_W'(j)] >= AGE_LIM) begin
                    next_pres[NODE_W'(j)] = 1'b0;
                    next_age[NODE_W'(j)]  = '0;
                end
            end else if (NODE_W'(j) == node_b) begin
                next_pres[NODE_W'(j)] = 1'b1;
                next_age[NODE_W'(j)]  = '0;
            end else if (NODE_W'(j) != node_a && pres_row[NODE_W'(j)]) begin
                next_age[NODE_W'(j)] = sat_inc(age_row[NODE_W'(j)]);
            end
        end
        // Column 0 is the null node and always reads back as empty.
        next_pres[0] = 1'b0;
        next_age[0]  = '0;
        row_or       = |next_pres;
    end

endmodule

// File: rtl/gam_connection_mem_seq.sv
// Per-class symmetric edge store with handshake connect and swept pruning.
// Optional macro GAM_CONN_EDGE_COUNT_EN enables the live edge counter.
module gam_connection_mem_seq
    import gam_connection_mem_seq_pkg::*;
#(
    parameter int CLASS_COUNT = CLASS_COUNT_DEF,
    parameter int NODE_COUNT  = NODE_COUNT_DEF,
    parameter int AGE_W       = AGE_W_DEF,
    parameter int AGE_MAX     = AGE_MAX_DEF,
    parameter int CLS_W       = $clog2(CLASS_COUNT),
    parameter int NODE_W      = $clog2(NODE_COUNT)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic [CLS_W-1:0]                   cmd_class,
    input  logic [NODE_W-1:0]                  cmd_node1,
    input  logic [NODE_W-1:0]                  cmd_node2,
    output logic                               cmd_err,
    input  logic                               learning_done,
    output logic                               busy,
    output logic                               prune_done,
    output logic [CLASS_COUNT*NODE_COUNT-1:0]  node_isolated,
    input  logic [CLS_W-1:0]                   q_class,
    input  logic [NODE_W-1:0]                  q_node1,
    input  logic [NODE_W-1:0]                  q_node2,
    output logic                               q_present,
    output logic [AGE_W-1:0]                   q_age,
    output logic [15:0]                        edge_count
);

    localparam logic [CLS_W:0]  CLS_LIM  = (CLS_W+1)'(CLASS_COUNT);
    localparam logic [NODE_W:0] NODE_LIM = (NODE_W+1)'(NODE_COUNT);

    logic [NODE_COUNT-1:0]            pres_mem [CLASS_COUNT][NODE_COUNT];
    logic [NODE_COUNT-1:0][AGE_W-1:0] age_mem  [CLASS_COUNT][NODE_COUNT];
    logic [NODE_COUNT-1:0]            iso_mem  [CLASS_COUNT];

    gam_conn_state_e state, nstate;
    logic [CLS_W-1:0]  cls_r, pc, sel_cls, q_sel_cls;
    logic [NODE_W-1:0] a_r, b_r, pi, sel_row;
    logic ld_q, pend, rise, cmd_ok, last_row, prune_mode, row_or, q_ok;
    logic [NODE_COUNT-1:0]            cur_pres, nxt_pres;
    logic [NODE_COUNT-1:0][AGE_W-1:0] cur_age, nxt_age;

    function automatic logic cmd_check(input logic [CLS_W-1:0] c,
                                       input logic [NODE_W-1:0] a,
                                       input logic [NODE_W-1:0] b);
        return (c != '0) && ({1'b0, c} < CLS_LIM) &&
               (a != NODE_W'(NULL_NODE)) && (b != NODE_W'(NULL_NODE)) && (a != b) &&
               ({1'b0, a} < NODE_LIM) && ({1'b0, b} < NODE_LIM);
    endfunction

    assign rise       = learning_done & ~ld_q;
    assign cmd_ok     = cmd_check(cls_r, a_r, b_r);
    assign last_row   = (pc == CLS_W'(CLASS_COUNT-1)) && (pi == NODE_W'(NODE_COUNT-1));
    assign prune_mode = (state == PRUNE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nstate;
    end

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE: begin
                if (rise || pend)                nstate = PRUNE;
                else if (cmd_valid && cmd_ready) nstate = CONNECT;
            end
            CONNECT: nstate = IDLE;
            PRUNE:   if (last_row) nstate = DONE;
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        cmd_ready  = (state == IDLE) && !learning_done && !pend;
        cmd_err    = (state == CONNECT) && !cmd_ok;
        prune_done = (state == DONE);
    end

    // A rise seen while busy is remembered; the DONE cycle retires it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_q  <= 1'b0;
            pend  <= 1'b0;
            cls_r <= '0;
            a_r   <= '0;
            b_r   <= '0;
            pc    <= '0;
            pi    <= '0;
        end else begin
            ld_q <= learning_done;
            pend <= (pend && state != DONE) || (rise && state != IDLE);
            if (state == IDLE && cmd_valid && cmd_ready) begin
                cls_r <= cmd_class;
                a_r   <= cmd_node1;
                b_r   <= cmd_node2;
            end
            if (state == IDLE) begin
                pc <= CLS_W'(1);
                pi <= NODE_W'(1);
            end else if (state == PRUNE) begin
                if (pi == NODE_W'(NODE_COUNT-1)) begin
                    pi <= NODE_W'(1);
                    pc <= pc + 1'b1;
                end else begin
                    pi <= pi + 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_cls = '0;
        sel_row = '0;
        if (state == PRUNE) begin
            sel_cls = pc;
            sel_row = pi;
        end else if (cmd_ok) begin
            sel_cls = cls_r;
            sel_row = a_r;
        end
    end

    assign cur_pres = pres_mem[sel_cls][sel_row];
    assign cur_age  = age_mem[sel_cls][sel_row];

    gam_conn_row_update #(
        .NODE_COUNT (NODE_COUNT),
        .NODE_W     (NODE_W),
        .AGE_W      (AGE_W),
        .AGE_MAX    (AGE_MAX)
    ) u_row_update (
        .prune_mode (prune_mode),
        .node_a     (a_r),
        .node_b     (b_r),
        .pres_row   (cur_pres),
        .age_row    (cur_age),
        .next_pres  (nxt_pres),
        .next_age   (nxt_age),
        .row_or     (row_or)
    );

    // Connect writes row a and mirrors it into column a to keep the matrix symmetric.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pres_mem <= '{default: '0};
            age_mem  <= '{default: '0};
            iso_mem  <= '{default: '0};
        end else if (state == CONNECT && cmd_ok) begin
            pres_mem[cls_r][a_r] <= nxt_pres;
            age_mem[cls_r][a_r]  <= nxt_age;
            for (int j = 1; j < NODE_COUNT; j++) begin
                pres_mem[cls_r][NODE_W'(j)][a_r] <= nxt_pres[NODE_W'(j)];
                age_mem[cls_r][NODE_W'(j)][a_r]  <= nxt_age[NODE_W'(j)];
            end
        end else if (state == PRUNE) begin
            pres_mem[pc][pi] <= nxt_pres;
            age_mem[pc][pi]  <= nxt_age;
            iso_mem[pc][pi]  <= ~row_or;
        end
    end

    for (genvar c = 0; c < CLASS_COUNT; c++) begin : g_iso
        assign node_isolated[c*NODE_COUNT +: NODE_COUNT] = iso_mem[c];
    end

    assign q_ok      = ({1'b0, q_class} < CLS_LIM);
    assign q_sel_cls = q_ok ? q_class : '0;
    assign q_present = q_ok & pres_mem[q_sel_cls][q_node1][q_node2];
    assign q_age     = q_ok ? age_mem[q_sel_cls][q_node1][q_node2] : '0;

`ifdef GAM_CONN_EDGE_COUNT_EN
    logic [15:0] edge_cnt, pruned_cnt;

    // Each undirected edge is seen from both rows; only the upper triangle counts.
    always_comb begin
        pruned_cnt = '0;
        for (int j = 1; j < NODE_COUNT; j++) begin
            if (j > int'(pi) && cur_pres[NODE_W'(j)] && !nxt_pres[NODE_W'(j)])
                pruned_cnt = pruned_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            edge_cnt <= '0;
        else if (state == CONNECT && cmd_ok && !cur_pres[b_r])
            edge_cnt <= edge_cnt + 16'd1;
        else if (state == PRUNE)
            edge_cnt <= edge_cnt - pruned_cnt;
    end

    assign edge_count = edge_cnt;
`else
    assign edge_count = 16'd0;
`endif

endmodule

// File: tb/tb_gam_connection_mem_seq.sv
// Self-checking bench for gam_connection_mem_seq: directed plan scenarios plus
// randomized traffic against an abstract matrix model.
module tb_gam_connection_mem_seq;

    localparam int CC   = 3;
    localparam int NC   = 8;
    localparam int AW   = 4;
    localparam int AM   = 3;
    localparam int CW   = 2;
    localparam int NW   = 3;
    localparam int ROWS = (CC-1)*(NC-1);
    localparam int SAT  = 15;
`ifdef GAM_CONN_EDGE_COUNT_EN
    localparam bit EC_EN = 1'b1;
`else
    localparam bit EC_EN = 1'b0;
`endif

    logic          clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, learning_done = 1'b0;
    logic [CW-1:0] cmd_class = '0, q_class = '0;
    logic [NW-1:0] cmd_node1 = '0, cmd_node2 = '0, q_node1 = '0, q_node2 = '0;
    logic          cmd_ready, cmd_err, busy, prune_done, q_present;
    logic [CC*NC-1:0] node_isolated;
    logic [AW-1:0] q_age;
    logic [15:0]   edge_count;

    gam_connection_mem_seq #(
        .CLASS_COUNT(CC), .NODE_COUNT(NC), .AGE_W(AW), .AGE_MAX(AM)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_class(cmd_class),
        .cmd_node1(cmd_node1), .cmd_node2(cmd_node2), .cmd_err(cmd_err),
        .learning_done(learning_done), .busy(busy), .prune_done(prune_done),
        .node_isolated(node_isolated),
        .q_class(q_class), .q_node1(q_node1), .q_node2(q_node2),
        .q_present(q_present), .q_age(q_age), .edge_count(edge_count)
    );

    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- abstract model ----------------
    bit m_pres [CC][NC][NC];
    int m_age  [CC][NC][NC];
    bit m_iso  [CC][NC];
    int m_cnt = 0, m_prune_left = 0;
    bit m_ld_prev = 0, m_pend = 0, m_conn = 0, m_done = 0;
    int mc = 0, ma = 0, mb = 0;

    function automatic bit valid_cmd(input int c, input int a, input int b);
        return c >= 1 && c < CC && a >= 1 && a < NC && b >= 1 && b < NC && a != b;
    endfunction

    task automatic model_reset();
        foreach (m_pres[c, i, j]) begin
            m_pres[c][i][j] = 0;
            m_age[c][i][j]  = 0;
        end
        foreach (m_iso[c, i]) m_iso[c][i] = 0;
        m_cnt = 0; m_prune_left = 0;
        m_ld_prev = 0; m_pend = 0; m_conn = 0; m_done = 0;
    endtask

    task automatic do_connect();
        if (!valid_cmd(mc, ma, mb)) return;
        if (!m_pres[mc][ma][mb]) m_cnt++;
        for (int j = 1; j < NC; j++) begin
            if (j != ma && j != mb && m_pres[mc][ma][j]) begin
                m_age[mc][ma][j] = (m_age[mc][ma][j] < SAT) ? m_age[mc][ma][j] + 1 : SAT;
                m_age[mc][j][ma] = m_age[mc][ma][j];
            end
        end
        m_pres[mc][ma][mb] = 1; m_pres[mc][mb][ma] = 1;
        m_age[mc][ma][mb]  = 0; m_age[mc][mb][ma]  = 0;
    endtask

    task automatic do_prune();
        for (int c = 1; c < CC; c++) begin
            for (int i = 1; i < NC; i++)
                for (int j = i + 1; j < NC; j++)
                    if (m_pres[c][i][j] && m_age[c][i][j] >= AM) begin
                        m_pres[c][i][j] = 0; m_pres[c][j][i] = 0;
                        m_age[c][i][j]  = 0; m_age[c][j][i]  = 0;
                        m_cnt--;
                    end
            for (int i = 1; i < NC; i++) begin
                bit any = 0;
                for (int j = 1; j < NC; j++) any |= m_pres[c][i][j];
                m_iso[c][i] = !any;
            end
        end
    endtask

    task automatic model_step();
        bit rise;
        rise = learning_done && !m_ld_prev;
        m_ld_prev = learning_done;
        if (m_conn) begin
            do_connect();
            m_conn = 0;
            if (rise) m_pend = 1;
        end else if (m_prune_left > 0) begin
            m_prune_left--;
            if (m_prune_left == 0) begin
                do_prune();
                m_done = 1;
            end
            if (rise) m_pend = 1;
        end else if (m_done) begin
            m_done = 0;
            m_pend = rise;
        end else if (rise || m_pend) begin
            m_prune_left = ROWS;
        end else if (cmd_valid && !learning_done) begin
            m_conn = 1;
            mc = int'(cmd_class); ma = int'(cmd_node1); mb = int'(cmd_node2);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    function automatic logic [CC*NC-1:0] iso_vec();
        logic [CC*NC-1:0] v = '0;
        for (int c = 0; c < CC; c++)
            for (int i = 0; i < NC; i++)
                v |= ({{(CC*NC-1){1'b0}}, m_iso[c][i]} << (c*NC + i));
        return v;
    endfunction

    // ---------------- per-cycle compare ----------------
    initial begin
        int rr = 0;
        bit bexp;
        forever begin
            @(negedge clk);
            #1;
            bexp = m_conn || (m_prune_left > 0) || m_done;
            check("busy", 64'(busy), 64'(bexp));
            check("cmd_ready", 64'(cmd_ready), 64'(!bexp && !learning_done && !m_pend));
            check("cmd_err", 64'(cmd_err), 64'(m_conn && !valid_cmd(mc, ma, mb)));
            check("prune_done", 64'(prune_done), 64'(m_done));
            if (m_prune_left == 0) begin
                int qc, qa;
                check("node_isolated", 64'(node_isolated), 64'(iso_vec()));
                check("edge_count", 64'(edge_count), EC_EN ? 64'(m_cnt) : 64'd0);
                qc = rr / NC; qa = rr % NC;
                rr = (rr + 1) % (4 * NC);
                q_class = CW'(qc); q_node1 = NW'(qa);
                for (int k = 0; k < NC; k++) begin
                    q_node2 = NW'(k);
                    #1;
                    check("q_present", 64'(q_present), (qc < CC) ? 64'(m_pres[qc][qa][k]) : 64'd0);
                    check("q_age", 64'(q_age), (qc < CC) ? 64'(m_age[qc][qa][k]) : 64'd0);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input int c, input int a, input int b);
        int t = 0;
        @(negedge clk);
        cmd_class = CW'(c); cmd_node1 = NW'(a); cmd_node2 = NW'(b); cmd_valid = 1'b1;
        #2;
        while (!cmd_ready && t < 100) begin
            @(negedge clk); #2; t++;
        end
        check("accept_timeout", 64'(t >= 100), 64'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, output int n);
        n = 0;
        forever begin
            @(negedge clk); #2;
            if (prune_done || n >= 200) break;
            n++;
        end
        check({name, "_timeout"}, 64'(n >= 200), 64'd0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #2;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(cmd_ready), 64'd1);
        check("rst_iso", 64'(node_isolated), 64'd0);
        check("rst_prune_done", 64'(prune_done), 64'd0);
        check("rst_err", 64'(cmd_err), 64'd0);

        // Single connect: handshake gap and model contents.
        send(1, 2, 3);
        n = 0; #2;
        while (!cmd_ready && n < 10) begin @(negedge clk); #2; n++; end
        check("ready_low_cycles", 64'(n), 64'd1);
        check("model_pres_23", 64'(m_pres[1][2][3]), 64'd1);
        check("model_pres_32", 64'(m_pres[1][3][2]), 64'd1);
        check("edge_count_one", 64'(edge_count), EC_EN ? 64'd1 : 64'd0);

        // Aging to the threshold, then prune on learning_done rise.
        repeat (3) send(1, 2, 4);
        @(negedge clk);
        check("model_age_23", 64'(m_age[1][2][3]), 64'd3);
        learning_done = 1'b1;
        @(posedge clk);
        wait_done("prune1", n);
        check("prune_latency", 64'(n), 64'd14);
        @(negedge clk); learning_done = 1'b0;
        #2;
        check("iso_1_3", 64'(node_isolated[11]), 64'd1);
        check("iso_1_2", 64'(node_isolated[10]), 64'd0);
        check("iso_1_4", 64'(node_isolated[12]), 64'd0);
        check("model_pruned_23", 64'(m_pres[1][2][3]), 64'd0);

        // Invalid commands.
        send(0, 2, 3); #2; check("err_c0", 64'(cmd_err), 64'd1);
        send(1, 0, 3); #2; check("err_n0", 64'(cmd_err), 64'd1);
        send(1, 5, 5); #2; check("err_same", 64'(cmd_err), 64'd1);
        @(negedge clk); #2;
        check("err_cleared", 64'(cmd_err), 64'd0);
        check("edge_count_after_err", 64'(edge_count), EC_EN ? 64'd1 : 64'd0);

        // Saturation.
        send(1, 2, 3);
        repeat (20) send(1, 2, 4);
        @(negedge clk);
        check("model_age_sat", 64'(m_age[1][2][3]), 64'd15);

        // Rise during CONNECT becomes a pending prune.
        send(1, 5, 6);
        learning_done = 1'b1;
        @(negedge clk); #2;
        check("pend_idle_busy", 64'(busy), 64'd0);
        check("pend_idle_ready", 64'(cmd_ready), 64'd0);
        wait_done("prune2", n);
        check("pend_prune_latency", 64'(n), 64'd14);
        repeat (2) @(negedge clk);
        #2; check("ready_blocked_ld", 64'(cmd_ready), 64'd0);
        @(negedge clk); learning_done = 1'b0;
        #2; check("ready_after_fall", 64'(cmd_ready), 64'd1);

        // Reset in the middle of a sweep, with learning_done held through release.
        @(negedge clk); learning_done = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #3; rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_iso", 64'(node_isolated), 64'd0);
        check("midrst_done", 64'(prune_done), 64'd0);
        check("midrst_count", 64'(edge_count), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #2;
        check("rise_through_reset", 64'(busy), 64'd1);
        wait_done("prune3", n);
        @(negedge clk); learning_done = 1'b0;

        // Randomized traffic.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            cmd_valid = ($urandom_range(0, 9) < 7);
            cmd_class = ($urandom_range(0, 9) < 8) ? CW'($urandom_range(1, 2)) : CW'($urandom_range(0, 3));
            cmd_node1 = ($urandom_range(0, 19) < 18) ? NW'($urandom_range(1, 7)) : NW'(0);
            cmd_node2 = ($urandom_range(0, 19) < 18) ? NW'($urandom_range(1, 7)) : NW'(0);
            if ($urandom_range(0, 99) < 3) learning_done = ~learning_done;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        learning_done = 1'b0;
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
